// File: rtl/exec_mem_pipe.sv
// exec_mem_pipe
//   Pipeline boundary between the exec stage and the memory stage. Each
//   instruction that exec hands over is captured into a two-entry skid buffer
//   (head H, tail T). The memory stage consumes entries from H through a
//   valid/ready handshake. ALU overflow (ADD/SUB only) and misaligned word
//   accesses turn the entry into a squashed exception record.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               discard held entries and the instruction presented now
//   ex_valid / ex_ready exec-side handshake; ex_ready is registered
//   ex_aluop            ALU operation code (selects whether overflow matters)
//   ex_alu_out          ALU result, also the load/store address
//   ex_overflow         ALU overflow flag
//   ex_pc, ex_rd        instruction PC and destination register
//   ex_regwrite, ex_memread, ex_memwrite, ex_byte   control fields
//   ex_store_data       store data
//   mem_valid / mem_ready                           memory-side handshake
//   mem_result, mem_pc, mem_store_data, mem_rd      head entry data
//   mem_regwrite, mem_memread, mem_memwrite, mem_byte  head entry control
//   mem_exc, mem_exc_cause  head exception flag, cause (01 ovf, 10 misaligned)
//   exc_pulse           one-cycle pulse after an excepting entry is captured
//   exc_pc              PC of the most recent excepting entry
module exec_mem_pipe #(
    parameter int         REG_SIZE  = 32,
    parameter int         RADDR_W   = 5,
    parameter logic [7:0] ALUOP_ADD = 8'h01,
    parameter logic [7:0] ALUOP_SUB = 8'h02
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [7:0]          ex_aluop,
    input  logic [REG_SIZE-1:0] ex_alu_out,
    input  logic                ex_overflow,
    input  logic [REG_SIZE-1:0] ex_pc,
    input  logic [RADDR_W-1:0]  ex_rd,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic                ex_memwrite,
    input  logic                ex_byte,
    input  logic [REG_SIZE-1:0] ex_store_data,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [REG_SIZE-1:0] mem_result,
    output logic [REG_SIZE-1:0] mem_pc,
    output logic [REG_SIZE-1:0] mem_store_data,
    output logic [RADDR_W-1:0]  mem_rd,
    output logic                mem_regwrite,
    output logic                mem_memread,
    output logic                mem_memwrite,
    output logic                mem_byte,
    output logic                mem_exc,
    output logic [1:0]          mem_exc_cause,
    output logic                exc_pulse,
    output logic [REG_SIZE-1:0] exc_pc
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    typedef struct packed {
        logic [REG_SIZE-1:0] result;
        logic [REG_SIZE-1:0] pc;
        logic [REG_SIZE-1:0] store_data;
        logic [RADDR_W-1:0]  rd;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
        logic                byte_op;
        logic                exc;
        logic [1:0]          cause;
    } entry_t;

    state_t              state_reg, state_next;
    entry_t              head_reg, head_next;
    entry_t              tail_reg, tail_next;
    entry_t              in_entry;
    logic                ex_ready_reg;
    logic                exc_pulse_reg;
    logic [REG_SIZE-1:0] exc_pc_reg;
    logic                acc;
    logic                drn;
    logic                ovf;
    logic                mis;

    assign acc = ex_valid & ex_ready_reg & ~flush;
    assign drn = (state_reg != ST_EMPTY) & mem_ready & ~flush;

    // Build the record for the incoming instruction. Overflow is only
    // meaningful for ADD/SUB; other ops leave the flag undefined. Overflow
    // takes priority over misalignment when both apply.
    always_comb begin
        ovf = ex_overflow & ((ex_aluop == ALUOP_ADD) | (ex_aluop == ALUOP_SUB));
        mis = (ex_memread | ex_memwrite) & ~ex_byte & (ex_alu_out[1:0] != 2'b00);

        in_entry            = '0;
        in_entry.result     = ex_alu_out;   // JUMP result is already 0 from the ALU
        in_entry.pc         = ex_pc;
        in_entry.store_data = ex_store_data;
        in_entry.rd         = ex_rd;
        in_entry.byte_op    = ex_byte;
        if (ovf | mis) begin
            // Squash all architectural side effects of the excepting instruction.
            in_entry.regwrite = 1'b0;
            in_entry.memread  = 1'b0;
            in_entry.memwrite = 1'b0;
            in_entry.exc      = 1'b1;
            in_entry.cause    = ovf ? 2'b01 : 2'b10;
        end else begin
            in_entry.regwrite = ex_regwrite;
            in_entry.memread  = ex_memread;
            in_entry.memwrite = ex_memwrite;
        end
    end

    // Occupancy FSM. H only changes on an EMPTY fill or a drain, so the
    // memory stage sees stable fields while it stalls.
    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        unique case (state_reg)
            ST_EMPTY: begin
                if (acc) begin
                    state_next = ST_ONE;
                    head_next  = in_entry;
                end
            end
            ST_ONE: begin
                if (acc & ~drn) begin
                    state_next = ST_TWO;
                    tail_next  = in_entry;
                end else if (acc & drn) begin
                    head_next  = in_entry;
                end else if (drn) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // ex_ready is low here, so no accept can coincide.
                if (drn) begin
                    state_next = ST_ONE;
                    head_next  = tail_reg;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush) begin
            state_next = ST_EMPTY;
            head_next  = '0;
            tail_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_EMPTY;
            head_reg      <= '0;
            tail_reg      <= '0;
            ex_ready_reg  <= 1'b0;
            exc_pulse_reg <= 1'b0;
            exc_pc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            // Registered ready: derived from next occupancy, never from mem_ready directly.
            ex_ready_reg  <= (state_next != ST_TWO);
            exc_pulse_reg <= acc & in_entry.exc;
            if (acc & in_entry.exc) begin
                exc_pc_reg <= ex_pc;
            end
        end
    end

    assign ex_ready       = ex_ready_reg;
    assign mem_valid      = (state_reg != ST_EMPTY);
    assign mem_result     = head_reg.result;
    assign mem_pc         = head_reg.pc;
    assign mem_store_data = head_reg.store_data;
    assign mem_rd         = head_reg.rd;
    assign mem_regwrite   = head_reg.regwrite;
    assign mem_memread    = head_reg.memread;
    assign mem_memwrite   = head_reg.memwrite;
    assign mem_byte       = head_reg.byte_op;
    assign mem_exc        = head_reg.exc;
    assign mem_exc_cause  = head_reg.cause;
    assign exc_pulse      = exc_pulse_reg;
    assign exc_pc         = exc_pc_reg;

endmodule
